coin_pulse_transmitter: RTL and testbench

COIN_PULSE_TRANSMITTER -- requirements
Module: coin_pulse_transmitter

---
 rtl/coin_pulse_transmitter.sv | 119 +++++++++++
 tb/tb_coin_pulse_transmitter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/coin_pulse_transmitter.sv
// Coin pulse transmitter: sends 1..3 high pulses on UART_TXD per accepted coin,
// followed by a quiet gap. Coin code is one-hot {pentagon, triangle, circle}.
module coin_pulse_transmitter #(
    parameter int PULSE_HIGH = 131072,
    parameter int PULSE_LOW  = 131072,
    parameter int GAP_CYCLES = 70000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [2:0] coin,
    output logic       coin_ready,
    output logic       UART_TXD,
    output logic       busy,
    output logic       coin_error,
    output logic [7:0] sent_count
);

    localparam logic [26:0] T_HIGH = 27'(PULSE_HIGH);
    localparam logic [26:0] T_LOW  = 27'(PULSE_LOW);
    localparam logic [26:0] T_GAP  = 27'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    state_t      state, state_nxt;
    logic [26:0] timer, timer_nxt;
    logic [1:0]  pcnt, pcnt_nxt;
    logic [1:0]  coin_n;
    logic        err_nxt;
    logic        cnt_inc;

    // Pulse count for the presented code; zero marks a non-one-hot code.
    always_comb begin
        coin_n = 2'd0;
        case (coin)
            3'b001:  coin_n = 2'd1;
            3'b010:  coin_n = 2'd2;
            3'b100:  coin_n = 2'd3;
            default: coin_n = 2'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        pcnt_nxt  = pcnt;
        err_nxt   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (coin_valid) begin
                    if (coin_n != 2'd0) begin
                        state_nxt = HIGH;
                        timer_nxt = T_HIGH;
                        pcnt_nxt  = coin_n;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (timer <= 27'd1) begin
                    state_nxt = LOW;
                    timer_nxt = T_LOW;
                end else begin
                    timer_nxt = timer - 27'd1;
                end
            end
            LOW: begin
                if (timer <= 27'd1) begin
                    pcnt_nxt = pcnt - 2'd1;
                    if (pcnt > 2'd1) begin
                        state_nxt = HIGH;
                        timer_nxt = T_HIGH;
                    end else begin
                        state_nxt = GAP;
                        timer_nxt = T_GAP;
                    end
                end else begin
                    timer_nxt = timer - 27'd1;
                end
            end
            GAP: begin
                if (timer <= 27'd1) begin
                    state_nxt = IDLE;
                    timer_nxt = 27'd0;
                    cnt_inc   = 1'b1;
                end else begin
                    timer_nxt = timer - 27'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // TXD is registered from the next state so it rises on the cycle after acceptance.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= 27'd0;
            pcnt       <= 2'd0;
            UART_TXD   <= 1'b0;
            coin_error <= 1'b0;
            sent_count <= 8'd0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            pcnt       <= pcnt_nxt;
            UART_TXD   <= (state_nxt == HIGH);
            coin_error <= err_nxt;
            if (cnt_inc)
                sent_count <= sent_count + 8'd1;
        end
    end

    assign coin_ready = (state == IDLE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_coin_pulse_transmitter.sv
// Directed bench for coin_pulse_transmitter with PULSE_HIGH=4, PULSE_LOW=3, GAP_CYCLES=10.
// Trace bit i holds the value seen in cycle i+1 after the acceptance edge.
module tb_coin_pulse_transmitter;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [2:0] coin;
    logic       coin_ready;
    logic       UART_TXD;
    logic       busy;
    logic       coin_error;
    logic [7:0] sent_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] tr_txd;
    logic [63:0] tr_busy;

    coin_pulse_transmitter #(
        .PULSE_HIGH(4),
        .PULSE_LOW (3),
        .GAP_CYCLES(10)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .coin_valid(coin_valid),
        .coin      (coin),
        .coin_ready(coin_ready),
        .UART_TXD  (UART_TXD),
        .busy      (busy),
        .coin_error(coin_error),
        .sent_count(sent_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // One-cycle request; returns in cycle 1 after the acceptance edge.
    task automatic send(input logic [2:0] c);
        coin_valid = 1'b1;
        coin       = c;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic run_trace(input int n, output logic [63:0] t, output logic [63:0] b);
        t = '0;
        b = '0;
        for (int i = 0; i < n; i++) begin
            t[i] = UART_TXD;
            b[i] = busy;
            step();
        end
    endtask

    logic [2:0] bad_codes [3] = '{3'b110, 3'b000, 3'b111};

    initial begin
        // Reset wins over a simultaneous request.
        reset      = 1'b1;
        coin_valid = 1'b1;
        coin       = 3'b001;
        step();
        step();
        chk("rst_txd",   64'(UART_TXD),   64'd0);
        chk("rst_busy",  64'(busy),       64'd0);
        chk("rst_ready", 64'(coin_ready), 64'd1);
        chk("rst_err",   64'(coin_error), 64'd0);
        chk("rst_cnt",   64'(sent_count), 64'd0);

        // Circle accepted on the very first edge after reset release.
        reset = 1'b0;
        step();
        coin_valid = 1'b0;
        run_trace(20, tr_txd, tr_busy);
        chk("circle_txd",   tr_txd,  64'h0000_0000_0000_000F);
        chk("circle_busy",  tr_busy, 64'h0000_0000_0001_FFFF);
        chk("circle_ready", 64'(coin_ready), 64'd1);
        chk("circle_cnt",   64'(sent_count), 64'd1);

        // Pentagon: three pulses, 31 busy cycles.
        send(3'b100);
        run_trace(33, tr_txd, tr_busy);
        chk("pent_txd",  tr_txd,  64'h0000_0000_0003_C78F);
        chk("pent_busy", tr_busy, 64'h0000_0000_7FFF_FFFF);
        chk("pent_cnt",  64'(sent_count), 64'd2);

        // Non-one-hot codes: one-cycle error strobe, no pulses, stay idle.
        foreach (bad_codes[k]) begin
            send(bad_codes[k]);
            chk("bad_err",   64'(coin_error), 64'd1);
            chk("bad_ready", 64'(coin_ready), 64'd1);
            chk("bad_txd",   64'(UART_TXD),   64'd0);
            chk("bad_busy",  64'(busy),       64'd0);
            step();
            chk("bad_err_clr", 64'(coin_error), 64'd0);
            chk("bad_cnt",     64'(sent_count), 64'd2);
        end

        // Triangle held: second train accepted in the first idle cycle (cycle 25).
        coin_valid = 1'b1;
        coin       = 3'b010;
        step();
        run_trace(49, tr_txd, tr_busy);
        coin_valid = 1'b0;
        chk("held_txd",  tr_txd,  64'h0000_000F_1E00_078F);
        chk("held_busy", tr_busy, 64'h0001_FFFF_FEFF_FFFF);
        chk("held_cnt",  64'(sent_count), 64'd4);
        step();
        chk("held_idle", 64'(busy), 64'd0);

        // Reset during the second HIGH of a triangle train, with a request pending.
        send(3'b010);
        repeat (8) step();
        chk("mid_txd_hi", 64'(UART_TXD), 64'd1);
        reset      = 1'b1;
        coin_valid = 1'b1;
        coin       = 3'b001;
        step();
        chk("abort_txd",   64'(UART_TXD),   64'd0);
        chk("abort_busy",  64'(busy),       64'd0);
        chk("abort_cnt",   64'(sent_count), 64'd0);
        chk("abort_ready", 64'(coin_ready), 64'd1);
        reset = 1'b0;
        step();
        coin_valid = 1'b0;
        run_trace(20, tr_txd, tr_busy);
        chk("post_txd",  tr_txd,  64'h0000_0000_0000_000F);
        chk("post_busy", tr_busy, 64'h0000_0000_0001_FFFF);
        chk("post_cnt",  64'(sent_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
